// File: rtl/clk_div_pkg.sv
// Shared defaults for the multi-channel clock divider and the ld_ch width helper.
package clk_div_pkg;
  localparam int          NCH_DEF  = 4;
  localparam int          CW_DEF   = 32;
  localparam int unsigned HALF_1HZ = 12_500_000;  // 1 Hz output from a 25 MHz clock

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: counts enabled cycles, toggles clk_out every eff(half) cycles,
// and swaps in a pending half-period only on a wrap edge.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int          CW       = CW_DEF,
  parameter int unsigned HALF_RST = HALF_1HZ
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          ld,
  input  logic [CW-1:0] ld_val,
  output logic          clk_out,
  output logic          tick,
  output logic          pend
);
  localparam logic [CW-1:0] HALF_INIT = CW'(HALF_RST);

  logic [CW-1:0] cnt_q, cnt_d, half_q, half_d, nxt_q, nxt_d, last;
  logic          clk_out_q, clk_out_d, tick_q, tick_d, pend_q, pend_d, wrap;

  always_comb begin
    // half==0 behaves as 1, so the terminal count is 0 in both cases
    last      = (half_q == '0) ? '0 : half_q - CW'(1);
    wrap      = en && (cnt_q == last);
    cnt_d     = cnt_q;
    half_d    = half_q;
    nxt_d     = nxt_q;
    pend_d    = pend_q;
    clk_out_d = clk_out_q;
    tick_d    = wrap;
    if (en) cnt_d = wrap ? '0 : cnt_q + CW'(1);
    if (wrap) clk_out_d = ~clk_out_q;
    // A load on a wrap edge wins: the older pending value is dropped, not applied.
    if (ld) begin
      nxt_d  = ld_val;
      pend_d = 1'b1;
    end else if (wrap && pend_q) begin
      half_d = nxt_q;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      half_q    <= HALF_INIT;
      nxt_q     <= HALF_INIT;
      pend_q    <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      half_q    <= half_d;
      nxt_q     <= nxt_d;
      pend_q    <= pend_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign pend    = pend_q;
endmodule

// File: rtl/clk_div_multi.sv
// NCH independent programmable clock dividers; the top only decodes the load strobe.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int          NCH      = NCH_DEF,
  parameter int          CW       = CW_DEF,
  parameter int unsigned HALF_RST = HALF_1HZ
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH-1:0]         en,
  input  logic                   ld,
  input  logic [ch_w(NCH)-1:0]   ld_ch,
  input  logic [CW-1:0]          ld_val,
  output logic [NCH-1:0]         clk_out,
  output logic [NCH-1:0]         tick,
  output logic [NCH-1:0]         pend
);
  localparam int CHW = ch_w(NCH);

  logic [NCH-1:0] ld_dec;

  // Selects >= NCH match no channel and are dropped here.
  always_comb begin
    ld_dec = '0;
    for (int i = 0; i < NCH; i++)
      if (ld && (ld_ch == CHW'(i))) ld_dec[i] = 1'b1;
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    clk_div_ch #(.CW(CW), .HALF_RST(HALF_RST)) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (en[g]),
      .ld      (ld_dec[g]),
      .ld_val  (ld_val),
      .clk_out (clk_out[g]),
      .tick    (tick[g]),
      .pend    (pend[g])
    );
  end
endmodule

// File: tb/tb_clk_div_multi.sv
// Randomized check of clk_div_multi against a toggle-interval model, plus directed pins.
module tb_clk_div_multi;
  localparam int NCH = 3;
  localparam int CW  = 8;
  localparam int HR  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [NCH-1:0] en;
  logic          ld;
  logic [1:0]    ld_ch;
  logic [CW-1:0] ld_val;
  logic [NCH-1:0] clk_out, tick, pend;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  clk_div_multi #(.NCH(NCH), .CW(CW), .HALF_RST(HR)) dut (
    .clk(clk), .rst(rst), .en(en), .ld(ld), .ld_ch(ld_ch), .ld_val(ld_val),
    .clk_out(clk_out), .tick(tick), .pend(pend)
  );

  always #5 clk = ~clk;

  // Model: each channel toggles after eff(half) enabled cycles since its last toggle.
  int run [NCH];
  int half[NCH];
  int nxt [NCH];
  logic [NCH-1:0] m_co, m_tk, m_pd;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        run[i] = 0; half[i] = HR; nxt[i] = HR;
      end
      m_co = '0; m_tk = '0; m_pd = '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        int e;
        bit w;
        e = (half[i] == 0) ? 1 : half[i];
        w = 1'b0;
        m_tk[i] = 1'b0;
        if (en[i]) begin
          run[i] = run[i] + 1;
          if (run[i] == e) begin
            run[i] = 0; m_co[i] = ~m_co[i]; m_tk[i] = 1'b1; w = 1'b1;
          end
        end
        if (ld && int'(ld_ch) == i) begin
          nxt[i] = int'(ld_val); m_pd[i] = 1'b1;
        end else if (w && m_pd[i]) begin
          half[i] = nxt[i]; m_pd[i] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      checks++;
      if (clk_out !== m_co) begin
        errors++; $display("FAIL clk_out t=%0t got %b want %b", $time, clk_out, m_co);
      end
      checks++;
      if (tick !== m_tk) begin
        errors++; $display("FAIL tick t=%0t got %b want %b", $time, tick, m_tk);
      end
      checks++;
      if (pend !== m_pd) begin
        errors++; $display("FAIL pend t=%0t got %b want %b", $time, pend, m_pd);
      end
    end
  end

  task automatic chk(input string name, input logic [NCH-1:0] got, input logic [NCH-1:0] want);
    checks++;
    if (got !== want) begin
      errors++; $display("FAIL %s got %b want %b", name, got, want);
    end
  endtask

  // Advance n edges; inputs change 2 time units after the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; en = '0; ld = 1'b0; ld_ch = '0; ld_val = '0;
    step(3);
    chk("reset_clk_out", clk_out, 3'b000);
    chk("reset_pend", pend, 3'b000);
    en = '1; rst = 1'b0; cmp_on = 1'b1;

    // Edges counted from reset release; half=3 toggles at 3, 6, 9 ...
    step(2);
    chk("e2_clk_out", clk_out, 3'b000);
    chk("e2_tick", tick, 3'b000);
    ld = 1'b1; ld_ch = 2'd0; ld_val = 8'd7;        // lands on ch0's wrap edge
    step(1);
    chk("e3_clk_out", clk_out, 3'b111);
    chk("e3_tick", tick, 3'b111);
    chk("e3_pend", pend, 3'b001);
    ld_val = 8'd5;                                  // overwrites the 7
    step(1);
    ld = 1'b0;
    chk("e4_tick", tick, 3'b000);
    step(2);
    chk("e6_clk_out", clk_out, 3'b000);
    chk("e6_pend", pend, 3'b000);
    step(3);
    chk("e9_tick", tick, 3'b110);
    step(1);
    chk("e10_clk_out", clk_out, 3'b110);
    step(1);
    chk("e11_tick", tick, 3'b001);
    chk("e11_clk_out", clk_out, 3'b111);

    // Fast-rate load on ch1 mid-period, plus an ignored out-of-range select.
    step(1);
    ld = 1'b1; ld_ch = 2'd1; ld_val = 8'd1;
    step(1);
    ld_ch = 2'd3; ld_val = 8'd2;
    step(1);
    ld = 1'b0;
    chk("ld_pend", pend, 3'b010);
    step(6);
    ld = 1'b1; ld_ch = 2'd2; ld_val = 8'd0;
    step(1);
    ld = 1'b0;
    step(8);

    // Freeze ch0 for five cycles mid-count.
    en[0] = 1'b0;
    step(5);
    chk("freeze_tick0", tick & 3'b001, 3'b000);
    en[0] = 1'b1;
    step(12);

    // Async reset mid-period with a load pending.
    ld = 1'b1; ld_ch = 2'd0; ld_val = 8'd9;
    step(1);
    ld = 1'b0;
    step(1);
    rst = 1'b1;
    #1;
    chk("async_rst_clk_out", clk_out, 3'b000);
    chk("async_rst_pend", pend, 3'b000);
    chk("async_rst_tick", tick, 3'b000);
    step(2);
    rst = 1'b0;
    step(3);
    chk("restart_tick", tick, 3'b111);

    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < NCH; i++) en[i] = ($urandom_range(0, 9) != 0);
      ld     = ($urandom_range(0, 9) == 0);
      ld_ch  = 2'($urandom_range(0, 3));
      ld_val = 8'($urandom_range(0, 6));
      rst    = ($urandom_range(0, 599) == 0);
      step(1);
    end
    rst = 1'b0; ld = 1'b0;
    step(2);
    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/clk_div_multi.md
CLK_DIV_MULTI -- requirements
Module: clk_div_multi

Interface
REQ-001 SHALL have parameter NCH, default 4, giving the number of independent divider channels (1..16).
REQ-002 SHALL have parameter CW, default 32, giving the width of the counter and the half-period register.
REQ-003 SHALL have parameter HALF_RST, default 12_500_000, giving the half-period (in clk cycles) loaded into every channel at reset.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port en, input, NCH bits: per-channel run enable.
REQ-007 SHALL have port ld, input, 1 bit: one-cycle strobe that loads a new half-period.
REQ-008 SHALL have port ld_ch, input, clog2(NCH) bits (minimum 1): target channel for ld.
REQ-009 SHALL have port ld_val, input, CW bits: new half-period value.
REQ-010 SHALL have port clk_out, output, NCH bits, registered: divided square wave per channel.
REQ-011 SHALL have port tick, output, NCH bits, registered: one-cycle pulse on every clk_out toggle.
REQ-012 SHALL have port pend, output, NCH bits, registered: a loaded value is waiting to take effect.

Function
REQ-013 Each channel SHALL hold a counter cnt[CW], an active half-period half[CW] and a pending register nxt[CW].
REQ-014 When en[i]=1 and cnt==eff(half)-1, the channel SHALL, on the next edge, set cnt to 0, invert clk_out[i] and assert tick[i] for exactly one cycle.
REQ-015 When en[i]=1 and no wrap occurs, cnt SHALL increment by 1 and tick[i] SHALL be 0.
REQ-016 eff(half) SHALL be half, except that half==0 SHALL behave as 1 (toggle every cycle).
REQ-017 The output period SHALL be 2*eff(half) clk cycles with 50% duty cycle.
REQ-018 When en[i]=0, cnt, clk_out[i] and half SHALL hold, tick[i] SHALL be 0, and pending loads SHALL stay pending.
REQ-019 ld=1 SHALL write ld_val into nxt[ld_ch] and set pend[ld_ch] on the next edge; ld_ch>=NCH SHALL be ignored.
REQ-020 A pending value SHALL be copied into half only at a wrap edge (REQ-014), and pend SHALL clear on that same edge, so no partial period ever occurs.
REQ-021 ld arriving on the same edge as that channel's wrap SHALL NOT apply immediately; the new value SHALL become pending and apply at the following wrap, and the old nxt SHALL be discarded.
REQ-022 A second ld to a channel that is already pending SHALL overwrite nxt; only the last value SHALL apply.
REQ-023 Counter overflow SHALL be impossible: cnt never exceeds eff(half)-1, and CW-bit arithmetic SHALL be unsigned.
REQ-024 Channels SHALL be fully independent; activity on one SHALL NOT affect another's timing.

Reset
REQ-025 While rst=1, every channel SHALL have cnt=0, clk_out=0, tick=0, pend=0 and half=nxt=HALF_RST[CW-1:0], immediately and independent of clk.
REQ-026 After rst deasserts, a channel with en=1 SHALL produce its first toggle HALF_RST edges later.
REQ-027 Reset mid-period or during a pending load SHALL discard all counts and pending values.

Structure
REQ-028 A shared package clk_div_pkg SHALL hold the defaults NCH_DEF=4, CW_DEF=32 and HALF_1HZ=12_500_000 (a 1 Hz output from 25 MHz), plus a helper for the ld_ch width.
REQ-029 One sub-module, clk_div_ch (one channel: cnt, half, nxt, pend, clk_out, tick), SHALL be instantiated NCH times with a generate loop; the top level decodes ld/ld_ch only.

Verification
REQ-030 HALF_RST=3, NCH=2, en=11, release rst -> clk_out toggles at edges 3, 6, 9..., tick is high for one cycle at each toggle, period is 6.
REQ-031 ld=1, ld_ch=1, ld_val=1 mid-period -> pend[1]=1 until the next wrap of channel 1, then it toggles every cycle; channel 0 is unchanged.
REQ-032 ld_val=0 -> the channel toggles every cycle, identical to ld_val=1.
REQ-033 en[0]=0 for 5 cycles mid-count -> clk_out[0] and cnt are frozen and tick[0]=0; on resume the period completes with the remaining count.
REQ-034 ld on the exact wrap edge, followed by a second ld with value 5 -> the first value is discarded and half=5 applies at the next wrap.
REQ-035 rst asserted asynchronously mid-period with a load pending -> all outputs are 0 at once, and the channel restarts with HALF_RST.
